// File: rtl/pla_onset_scanner.sv
// Drives every input vector into a single-output PLA and streams each on-set minterm out.
// Accumulates count/first/last/XOR of the on-set; stalls the walk under output backpressure.
module pla_onset_scanner #(
    parameter int N_IN  = 12,
    parameter int CNT_W = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  vec_o,
    input  logic             y_i,
    output logic             m_valid,
    output logic [N_IN-1:0]  m_data,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] onset_count,
    output logic             any_on,
    output logic [N_IN-1:0]  first_min,
    output logic [N_IN-1:0]  last_min,
    output logic [N_IN-1:0]  xor_acc
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t state, state_nxt;
    logic   slot_free;
    logic   accept;
    logic   advance;
    logic   last_vec;

    assign slot_free = !m_valid || m_ready;
    assign last_vec  = &vec_o;
    // A stalled on-set vector must not advance, otherwise its minterm would be lost.
    assign accept    = (state == SCAN) && !abort && y_i && slot_free;
    assign advance   = (state == SCAN) && !abort && (!y_i || slot_free);
    assign busy      = (state == SCAN) || (state == DRAIN);
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = SCAN;
            SCAN: begin
                if (abort)                    state_nxt = IDLE;
                else if (advance && last_vec) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (abort)          state_nxt = IDLE;
                else if (slot_free) state_nxt = DONE;
            end
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_o       <= '0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            onset_count <= '0;
            any_on      <= 1'b0;
            first_min   <= '0;
            last_min    <= '0;
            xor_acc     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec_o       <= '0;
                        onset_count <= '0;
                        any_on      <= 1'b0;
                        first_min   <= '0;
                        last_min    <= '0;
                        xor_acc     <= '0;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        m_valid <= 1'b0;
                    end else begin
                        if (m_valid && m_ready) m_valid <= 1'b0;
                        if (accept) begin
                            m_data      <= vec_o;
                            m_valid     <= 1'b1;
                            onset_count <= onset_count + CNT_W'(1);
                            xor_acc     <= xor_acc ^ vec_o;
                            last_min    <= vec_o;
                            if (!any_on) begin
                                first_min <= vec_o;
                                any_on    <= 1'b1;
                            end
                        end
                        // The all-ones vector stays on the bus through DRAIN.
                        if (advance && !last_vec) vec_o <= vec_o + N_IN'(1);
                    end
                end
                DRAIN: begin
                    if (abort || m_ready) m_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pla_onset_scanner.sv
// Scoreboard bench: expected minterms are queued at scan start and popped by a monitor on each handshake.
module tb_pla_onset_scanner;

    localparam int N_IN  = 12;
    localparam int CNT_W = 13;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [N_IN-1:0]  vec_o;
    logic             y_i;
    logic             m_valid;
    logic [N_IN-1:0]  m_data;
    logic             m_ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] onset_count;
    logic             any_on;
    logic [N_IN-1:0]  first_min;
    logic [N_IN-1:0]  last_min;
    logic [N_IN-1:0]  xor_acc;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int mode     = 0;   // 0: y=0, 1: y=1, 2: single minterm 0x0E3
    bit rnd_rdy  = 1'b0;
    bit chk_stab = 1'b0;
    logic [N_IN-1:0] sb[$];

    pla_onset_scanner #(.N_IN(N_IN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec_o(vec_o),
        .y_i(y_i), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .busy(busy), .done(done), .onset_count(onset_count), .any_on(any_on),
        .first_min(first_min), .last_min(last_min), .xor_acc(xor_acc)
    );

    always #5 clk = ~clk;

    // Netlist stand-in: x0&x1&~x2&~x3&~x4&x5&x6&x7&~x8..~x11 is the minterm 0x0E3.
    always_comb begin
        y_i = 1'b0;
        case (mode)
            1: y_i = 1'b1;
            2: y_i = vec_o[0] & vec_o[1] & ~vec_o[2] & ~vec_o[3] & ~vec_o[4] & vec_o[5]
                   & vec_o[6] & vec_o[7] & ~vec_o[8] & ~vec_o[9] & ~vec_o[10] & ~vec_o[11];
            default: y_i = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 m_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: every handshake pops the next expected minterm.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                chk_cnt++;
                $display("FAIL beat_extra: got 0x%0h expected no beat at %0t", m_data, $time);
            end else begin
                chk("beat_data", 32'(m_data), 32'(sb.pop_front()));
            end
        end
    end

    // Backpressure monitor: data must hold while stalled, and the walk must not move.
    logic            stall_prev = 1'b0;
    logic            hold_prev  = 1'b0;
    logic [N_IN-1:0] data_prev;
    logic [N_IN-1:0] vec_prev;
    always @(negedge clk) begin
        if (chk_stab && rst_n) begin
            if (stall_prev) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data", 32'(m_data), 32'(data_prev));
            end
            if (hold_prev) chk("stall_vec", 32'(vec_o), 32'(vec_prev));
        end
        stall_prev = m_valid && !m_ready;
        hold_prev  = busy && y_i && m_valid && !m_ready;
        data_prev  = m_data;
        vec_prev   = vec_o;
    end

    task automatic start_scan();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int pulse_at, output int cyc);
        cyc = 0;
        while (!done && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == pulse_at);
        end
        start = 1'b0;
        if (!done) begin
            chk_cnt++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
        end
    endtask

    task automatic check_results(input int cnt, input logic any, input logic [N_IN-1:0] first,
                                 input logic [N_IN-1:0] last, input logic [N_IN-1:0] xr);
        chk("onset_count", 32'(onset_count), 32'(cnt));
        chk("any_on", 32'(any_on), 32'(any));
        chk("first_min", 32'(first_min), 32'(first));
        chk("last_min", 32'(last_min), 32'(last));
        chk("xor_acc", 32'(xor_acc), 32'(xr));
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("busy_in_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("hold_count", 32'(onset_count), 32'(cnt));
    endtask

    task automatic push_all();
        for (int v = 0; v < (1 << N_IN); v++) sb.push_back(N_IN'(v));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_vec"}, 32'(vec_o), 32'd0);
        chk({tag, "_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_data"}, 32'(m_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_count"}, 32'(onset_count), 32'd0);
        chk({tag, "_any"}, 32'(any_on), 32'd0);
        chk({tag, "_first"}, 32'(first_min), 32'd0);
        chk({tag, "_last"}, 32'(last_min), 32'd0);
        chk({tag, "_xor"}, 32'(xor_acc), 32'd0);
    endtask

    initial begin
        int cyc;
        logic seen_done;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        #22;
        check_zero("reset");
        rst_n = 1'b1;

        // Single minterm, free-flowing output.
        mode = 2;
        sb.push_back(12'h0E3);
        start_scan();
        wait_done(-1, cyc);
        chk("single_latency", 32'(cyc), 32'd4097);
        check_results(1, 1'b1, 12'h0E3, 12'h0E3, 12'h0E3);

        // Tautology: every vector streamed in order.
        mode = 1;
        push_all();
        start_scan();
        wait_done(-1, cyc);
        chk("all_latency", 32'(cyc), 32'd4097);
        check_results(32'h1000, 1'b1, 12'h000, 12'hFFF, 12'h000);

        // Tautology under random backpressure.
        rnd_rdy  = 1'b1;
        chk_stab = 1'b1;
        push_all();
        start_scan();
        wait_done(-1, cyc);
        chk("rnd_stalled", 32'(cyc > 4097), 32'd1);
        check_results(32'h1000, 1'b1, 12'h000, 12'hFFF, 12'h000);
        rnd_rdy  = 1'b0;
        chk_stab = 1'b0;
        @(posedge clk);

        // Empty on-set, with a start pulse mid-scan that must be ignored.
        mode = 0;
        start_scan();
        wait_done(100, cyc);
        chk("empty_latency", 32'(cyc), 32'd4097);
        check_results(0, 1'b0, 12'h000, 12'h000, 12'h000);

        // Abort after the single minterm has been emitted.
        mode = 2;
        sb.push_back(12'h0E3);
        start_scan();
        repeat (499) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(m_valid), 32'd0);
        chk("abort_count", 32'(onset_count), 32'd1);
        chk("abort_any", 32'(any_on), 32'd1);
        chk("abort_sb", 32'(sb.size()), 32'd0);
        seen_done = 1'b0;
        repeat (10) begin
            seen_done |= done;
            @(posedge clk);
            #1;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);
        sb.push_back(12'h0E3);
        start_scan();
        wait_done(-1, cyc);
        chk("rescan_latency", 32'(cyc), 32'd4097);
        check_results(1, 1'b1, 12'h0E3, 12'h0E3, 12'h0E3);

        // Reset mid-scan while a beat is in flight.
        mode = 1;
        push_all();
        start_scan();
        repeat (50) @(posedge clk);
        #1;
        chk("pre_reset_valid", 32'(m_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("post_reset_idle", 32'(busy), 32'd0);
        push_all();
        start_scan();
        chk("restart_vec", 32'(vec_o), 32'd0);
        wait_done(-1, cyc);
        chk("restart_latency", 32'(cyc), 32'd4097);
        check_results(32'h1000, 1'b1, 12'h000, 12'hFFF, 12'h000);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pla_onset_scanner.md
Name: pla_onset_scanner

Overview:
- Sequential driver placed directly upstream of a 12-input single-output PLA restriction netlist.
- Walks all 2^N_IN input vectors into the netlist and samples the combinational output y0.
- Streams every on-set minterm out over a valid/ready port.
- Accumulates on-set statistics (count, first, last, XOR-fold) used by the autosymmetry experiments to check restricted functions.

Parameters:
- N_IN, 12, width of the input vector driven into the netlist (bit i of vec_o drives xi).
- CNT_W, 13, width of onset_count; must be ≥ N_IN+1 so that 2^N_IN is representable.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begins a scan; sampled only in IDLE.
- abort  in  1  synchronous abandon of a scan in progress.
- vec_o  out  N_IN  current vector driven to x0..x(N_IN-1).
- y_i  in  1  netlist output y0 for vec_o in the same cycle (purely combinational path).
- m_valid  out  1  minterm output valid.
- m_data  out  N_IN  on-set minterm.
- m_ready  in  1  downstream accepts m_data.
- busy  out  1  high in SCAN and DRAIN.
- done  out  1  one-cycle pulse when a scan completes.
- onset_count  out  CNT_W  number of on-set minterms found.
- any_on  out  1  at least one minterm found.
- first_min  out  N_IN  lowest on-set minterm.
- last_min  out  N_IN  highest on-set minterm.
- xor_acc  out  N_IN  XOR of all on-set minterms.

Behaviour:
- Reset (rst_n=0, async): state IDLE. All outputs are 0: vec_o, m_valid, m_data, busy, done, onset_count, any_on, first_min, last_min, xor_acc.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - start=1 at an edge → SCAN.
  - The same edge sets vec_o=0 and clears onset_count, any_on, first_min, last_min and xor_acc.
  - m_valid is untouched (it is already 0 in IDLE).
- SCAN, per edge:
  - Output slot is free when m_valid=0 or m_ready=1. A handshake (m_valid & m_ready) clears m_valid unless it is reloaded on the same edge.
  - y_i=1 and slot free (accept):
    - m_data←vec_o, m_valid←1, onset_count+1, xor_acc^=vec_o, last_min←vec_o.
    - first_min←vec_o and any_on←1 only if any_on was 0.
    - Then advance.
  - y_i=1 and slot not free (stall): vec_o is held and no accumulator changes. Stall cycles are unbounded.
  - y_i=0: advance.
  - Advance: vec_o all-ones → DRAIN, with vec_o held at all-ones. Otherwise vec_o+1.
- DRAIN: when m_valid=0, or it clears on this edge through a handshake → DONE.
- DONE: done=1 for exactly that cycle → IDLE on the next edge.
- busy=1 in SCAN and DRAIN only.
- Result outputs hold their values from DONE until the next accepted start.
- Stall-free timing: vector k is driven in cycle k after the start edge. DONE is entered at edge 2^N_IN+1 after start, so total latency is 2^N_IN+2 cycles including the DONE cycle.
- start while busy or in DONE: ignored.
- abort=1 in SCAN or DRAIN:
  - → IDLE next edge with m_valid←0 and no done pulse.
  - Accumulators keep their partial values.
  - abort has priority over accept and advance.
- abort in IDLE or DONE: ignored.
- Asserting rst_n mid-scan: immediate return to the reset values; the in-flight minterm is dropped.
- m_data and m_valid are stable while m_valid=1 and m_ready=0.
- onset_count never wraps, because CNT_W ≥ N_IN+1.
- Empty on-set: count=0, any_on=0, first_min=last_min=xor_acc=0.

Test Plan:
- Function y = x0&x1&~x2&~x3&~x4&x5&x6&x7&~x8&~x9&~x10&~x11, m_ready=1, start → exactly one beat m_data=0x0E3, onset_count=1, first_min=last_min=xor_acc=0x0E3, any_on=1, done 4097 cycles after the start edge.
- y tied to 1, m_ready=1 → 4096 beats 0x000..0xFFF in order, onset_count=0x1000, first_min=0x000, last_min=0xFFF, xor_acc=0x000, no stalls.
- y tied to 1, m_ready random at 50% → same beat sequence with no loss or duplication, m_data stable under backpressure, vec_o held during stalls, final results identical to the previous case.
- y tied to 0 → no m_valid, count=0, any_on=0, done at cycle 4097; start pulsed at cycle 100 is ignored.
- abort at cycle 500 of the single-minterm scan → IDLE, m_valid=0, no done, count=1 kept; a later start produces fresh, correct results.
- rst_n low at cycle 50 of the y=1 scan while m_valid=1 → all outputs 0 immediately, state IDLE, next start rescans from 0.
